// File: rtl/ssc_tx_capture.sv
// UART 8N1 capture of the SSC serial output into a byte FIFO.
// Define SSC_TX_CAPTURE_STATS_EN to add saturating error counters.
module ssc_tx_capture #(
  parameter int unsigned CLOCK_SPEED_HZ = 54_000_000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                          clk_logic_i,
  input  logic                          reset_i,
  input  logic                          serial_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
`ifdef SSC_TX_CAPTURE_STATS_EN
  output logic [7:0]                    frame_err_cnt_o,
  output logic [7:0]                    overrun_cnt_o,
`endif
  output logic                          overrun_o
);

  localparam int unsigned DIV =
    (CLOCK_SPEED_HZ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_n;

  logic          sync1, line, line_prev;
  logic [DW-1:0] clk_cnt, clk_cnt_n;
  logic [3:0]    tick_cnt, tick_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          push_q, push_n;
  logic          ferr_n;
  logic          tick;

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      sync1     <= 1'b1;
      line      <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= serial_i;
      line      <= sync1;
      line_prev <= line;
    end
  end

  assign tick = (clk_cnt == DW'(DIV - 1));

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      push_q      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      tick_cnt    <= tick_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      push_q      <= push_n;
      frame_err_o <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    clk_cnt_n  = tick ? '0 : clk_cnt + DW'(1);
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    push_n     = 1'b0;
    ferr_n     = 1'b0;
    unique case (state)
      S_IDLE: begin
        clk_cnt_n  = '0;
        tick_cnt_n = '0;
        if (line_prev && !line) begin
          state_n   = S_START;
          bit_cnt_n = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt == 4'd7) begin
            tick_cnt_n = '0;
            if (line) begin
              state_n   = S_IDLE;
              clk_cnt_n = '0;
            end else begin
              state_n = S_DATA;
            end
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shift_n   = {line, shift[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            tick_cnt_n = '0;
            if (line) begin
              push_n  = 1'b1;
              state_n = S_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        clk_cnt_n  = '0;
        tick_cnt_n = '0;
        if (line)
          state_n = S_IDLE;
      end
      default: begin
        state_n    = S_IDLE;
        clk_cnt_n  = '0;
        tick_cnt_n = '0;
      end
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [CW-1:0] count, count_n;
  logic          pop, full, push_ok, ovr_n;
  logic          head_bypass;

  assign valid_o = (count != '0);
  assign count_o = count;

  always_comb begin
    pop         = valid_o && ready_i;
    full        = (count == CW'(FIFO_DEPTH));
    push_ok     = push_q && (!full || pop);
    ovr_n       = push_q && full && !pop;
    rd_n        = rd_ptr + AW'(pop);
    count_n     = count + CW'(push_ok) - CW'(pop);
    head_bypass = push_ok && (wr_ptr == rd_n);
  end

  // Storage is not reset; the head register hides stale entries.
  always_ff @(posedge clk_logic_i) begin
    if (push_ok)
      mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_o    <= '0;
      overrun_o <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push_ok);
      rd_ptr    <= rd_n;
      count     <= count_n;
      overrun_o <= ovr_n;
      if (count_n != '0)
        data_o <= head_bypass ? shift : mem[rd_n];
    end
  end

`ifdef SSC_TX_CAPTURE_STATS_EN
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      frame_err_cnt_o <= '0;
      overrun_cnt_o   <= '0;
    end else begin
      if (frame_err_o && frame_err_cnt_o != 8'hFF)
        frame_err_cnt_o <= frame_err_cnt_o + 8'd1;
      if (overrun_o && overrun_cnt_o != 8'hFF)
        overrun_cnt_o <= overrun_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ssc_tx_capture.sv
// Directed bench for ssc_tx_capture at 4 clocks per tick (64 per bit).
// Covers single byte, overrun, framing error, glitch, full push+pop, reset.
module tb_ssc_tx_capture;

  localparam int unsigned BAUD = 9600;
  localparam int unsigned CLK_HZ = 16 * BAUD * 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BIT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [4:0] count;
  logic       ferr;
  logic       ovr;
`ifdef SSC_TX_CAPTURE_STATS_EN
  logic [7:0] ferr_cnt;
  logic [7:0] ovr_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int       vcyc = 0;
  int       nferr = 0;
  int       novr = 0;
  bit [7:0] popq[$];

  always #5 clk = ~clk;

  ssc_tx_capture #(
    .CLOCK_SPEED_HZ(CLK_HZ),
    .BAUD_RATE(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_logic_i(clk),
    .reset_i(rst),
    .serial_i(serial),
    .data_o(data),
    .valid_o(valid),
    .ready_i(ready),
    .count_o(count),
    .frame_err_o(ferr),
`ifdef SSC_TX_CAPTURE_STATS_EN
    .frame_err_cnt_o(ferr_cnt),
    .overrun_cnt_o(ovr_cnt),
`endif
    .overrun_o(ovr)
  );

  always @(negedge clk) begin
    if (valid && ready) popq.push_back(data);
    if (valid) vcyc <= vcyc + 1;
    if (ferr) nferr <= nferr + 1;
    if (ovr) novr <= novr + 1;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    serial = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      clks(BIT);
    end
    serial = stop;
    clks(BIT);
  endtask

  task automatic test_reset;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got %0b want 0", valid);
    end
    n_cmp++;
    if (count !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    n_cmp++;
    if (data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data got %0h want 0", data);
    end
    n_cmp++;
    if (ferr !== 1'b0 || ovr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pulses got %0b%0b want 00", ferr, ovr);
    end
  endtask

  task automatic test_single;
    int v0, f0, q0;
    ready = 1'b1;
    v0 = vcyc; f0 = nferr; q0 = popq.size();
    send_byte(8'hA5, 1'b1);
    clks(BIT);
    n_cmp++;
    if (vcyc - v0 !== 1) begin
      n_bad++;
      $display("FAIL single_valid_cycles got %0d want 1", vcyc - v0);
    end
    n_cmp++;
    if (popq.size() - q0 !== 1) begin
      n_bad++;
      $display("FAIL single_pops got %0d want 1", popq.size() - q0);
    end else begin
      n_cmp++;
      if (popq[q0] !== 8'hA5) begin
        n_bad++;
        $display("FAIL single_data got %0h want a5", popq[q0]);
      end
    end
    n_cmp++;
    if (nferr - f0 !== 0) begin
      n_bad++;
      $display("FAIL single_ferr got %0d want 0", nferr - f0);
    end
  endtask

  task automatic test_overrun;
    int o0, q0;
    ready = 1'b0;
    o0 = novr;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    n_cmp++;
    if (novr - o0 !== 0) begin
      n_bad++;
      $display("FAIL ovr_early got %0d want 0", novr - o0);
    end
    send_byte(8'h10, 1'b1);
    clks(4);
    n_cmp++;
    if (novr - o0 !== 1) begin
      n_bad++;
      $display("FAIL ovr_pulses got %0d want 1", novr - o0);
    end
    n_cmp++;
    if (count !== 5'd16) begin
      n_bad++;
      $display("FAIL ovr_count got %0d want 16", count);
    end
    q0 = popq.size();
    ready = 1'b1;
    clks(40);
    n_cmp++;
    if (popq.size() - q0 !== 16) begin
      n_bad++;
      $display("FAIL ovr_drain got %0d want 16", popq.size() - q0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (popq[q0 + i] !== 8'(i)) begin
          n_bad++;
          $display("FAIL ovr_order[%0d] got %0h want %0h",
                   i, popq[q0 + i], i);
        end
      end
    end
    n_cmp++;
    if (count !== 5'd0) begin
      n_bad++;
      $display("FAIL ovr_empty got %0d want 0", count);
    end
  endtask

  task automatic test_frame_err;
    int f0, q0;
    ready = 1'b1;
    f0 = nferr; q0 = popq.size();
    send_byte(8'h55, 1'b0);
    clks(3 * BIT);
    serial = 1'b1;
    clks(BIT);
    n_cmp++;
    if (nferr - f0 !== 1) begin
      n_bad++;
      $display("FAIL ferr_pulses got %0d want 1", nferr - f0);
    end
    n_cmp++;
    if (popq.size() - q0 !== 0) begin
      n_bad++;
      $display("FAIL ferr_push got %0d want 0", popq.size() - q0);
    end
    send_byte(8'h3C, 1'b1);
    clks(BIT);
    n_cmp++;
    if (popq.size() - q0 !== 1) begin
      n_bad++;
      $display("FAIL ferr_next_pops got %0d want 1", popq.size() - q0);
    end else begin
      n_cmp++;
      if (popq[q0] !== 8'h3C) begin
        n_bad++;
        $display("FAIL ferr_next_data got %0h want 3c", popq[q0]);
      end
    end
  endtask

  task automatic test_glitch;
    int f0, q0, v0;
    ready = 1'b1;
    f0 = nferr; q0 = popq.size(); v0 = vcyc;
    serial = 1'b0;
    clks(22);
    serial = 1'b1;
    clks(4 * BIT);
    n_cmp++;
    if (vcyc - v0 !== 0 || popq.size() - q0 !== 0) begin
      n_bad++;
      $display("FAIL glitch_push got %0d want 0", vcyc - v0);
    end
    n_cmp++;
    if (nferr - f0 !== 0) begin
      n_bad++;
      $display("FAIL glitch_ferr got %0d want 0", nferr - f0);
    end
    send_byte(8'h5A, 1'b1);
    clks(BIT);
    n_cmp++;
    if (popq.size() - q0 !== 1) begin
      n_bad++;
      $display("FAIL glitch_after_pops got %0d want 1", popq.size() - q0);
    end else begin
      n_cmp++;
      if (popq[q0] !== 8'h5A) begin
        n_bad++;
        $display("FAIL glitch_after_data got %0h want 5a", popq[q0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int o0, q0;
    ready = 1'b0;
    o0 = novr;
    q0 = popq.size();
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1);
    // Stop sample lands 611 clocks after the start bit, write on 612.
    fork
      send_byte(8'h30, 1'b1);
      begin
        clks(611);
        ready = 1'b1;
        clks(1);
        ready = 1'b0;
      end
    join
    n_cmp++;
    if (count !== 5'd16) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want 16", count);
    end
    n_cmp++;
    if (novr - o0 !== 0) begin
      n_bad++;
      $display("FAIL b2b_ovr got %0d want 0", novr - o0);
    end
    ready = 1'b1;
    clks(40);
    n_cmp++;
    if (popq.size() - q0 !== 17) begin
      n_bad++;
      $display("FAIL b2b_pops got %0d want 17", popq.size() - q0);
    end else begin
      for (int i = 0; i < 17; i++) begin
        n_cmp++;
        if (popq[q0 + i] !== 8'h20 + 8'(i)) begin
          n_bad++;
          $display("FAIL b2b_order[%0d] got %0h want %0h",
                   i, popq[q0 + i], 8'h20 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int q0;
    ready = 1'b0;
    send_byte(8'h11, 1'b1);
    n_cmp++;
    if (valid !== 1'b1 || data !== 8'h11) begin
      n_bad++;
      $display("FAIL rmid_pre got %0b/%0h want 1/11", valid, data);
    end
    b = 8'hC3;
    serial = 1'b0;
    clks(BIT);
    for (int i = 0; i < 4; i++) begin
      serial = b[i];
      clks(BIT);
    end
    serial = b[4];
    clks(BIT / 2);
    rst = 1'b1;
    #2;
    n_cmp++;
    if (valid !== 1'b0 || count !== 5'd0) begin
      n_bad++;
      $display("FAIL rmid_async got %0b/%0d want 0/0", valid, count);
    end
    n_cmp++;
    if (data !== 8'h00) begin
      n_bad++;
      $display("FAIL rmid_data got %0h want 0", data);
    end
    serial = 1'b1;
    clks(5);
    rst = 1'b0;
    clks(BIT);
    ready = 1'b1;
    q0 = popq.size();
    send_byte(8'h81, 1'b1);
    clks(BIT);
    n_cmp++;
    if (popq.size() - q0 !== 1) begin
      n_bad++;
      $display("FAIL rmid_pops got %0d want 1", popq.size() - q0);
    end else begin
      n_cmp++;
      if (popq[q0] !== 8'h81) begin
        n_bad++;
        $display("FAIL rmid_next got %0h want 81", popq[q0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    serial = 1'b1;
    ready = 1'b0;
    clks(5);
    test_reset;
    rst = 1'b0;
    clks(BIT);
    test_single;
    test_overrun;
    test_frame_err;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssc_tx_capture.md
SSC_TX_CAPTURE -- requirements
Module: ssc_tx_capture

Interface
- REQ-001: Parameter CLOCK_SPEED_HZ, default 54_000_000, logic clock frequency in Hz.
- REQ-002: Parameter BAUD_RATE, default 9600, serial bit rate. This matches the SSC SW1 baud setting.
- REQ-003: Parameter FIFO_DEPTH, default 16, byte FIFO depth. Must be a power of two, 2..256.
- REQ-004: clk_logic_i, input, 1, the single clock. All logic is on its rising edge.
- REQ-005: reset_i, input, 1, asynchronous active-high reset.
- REQ-006: serial_i, input, 1, serial line driven by the SSC uart_tx_o (idle high, 8N1).
- REQ-007: data_o, output, 8, byte at the FIFO head.
- REQ-008: valid_o, output, 1, FIFO not empty.
- REQ-009: ready_i, input, 1, consumer accepts data_o.
- REQ-010: count_o, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- REQ-011: frame_err_o, output, 1, one-cycle pulse when a stop bit is sampled low.
- REQ-012: overrun_o, output, 1, one-cycle pulse when a valid byte is dropped because the FIFO is full.

Function
- REQ-013: serial_i passes through a 2-flop synchronizer. Reset value is 1. Every reference to the line below means the synchronized value.
- REQ-014: Oversample tick period is DIV = round(CLOCK_SPEED_HZ/(16*BAUD_RATE)) clocks. Defaults give DIV = 352.
- REQ-015: The tick counter is held at 0 in IDLE and starts on the start-bit detect.
- REQ-016: States are IDLE, START, DATA, STOP and BREAK.
- REQ-017: IDLE: a high-to-low transition of the line moves to START and clears the tick and bit counters.
- REQ-018: START: the line is sampled at tick 7, the middle of the start bit.
  - Sample low: go to DATA with the tick counter reset.
  - Sample high: glitch. Return to IDLE with no output.
- REQ-019: DATA: every 16 ticks, sample and shift in one bit, LSB first. After bit 7, go to STOP.
- REQ-020: STOP: sample the line 16 ticks after the last data-bit sample.
  - High: push the byte and return to IDLE.
  - Low: pulse frame_err_o, discard the byte, go to BREAK.
- REQ-021: BREAK: stay until the line is high, then go to IDLE.
- REQ-022: A push happens the cycle after the stop sample. valid_o is high the following cycle.
- REQ-023: Pop occurs when valid_o and ready_i are both high at a clock edge. data_o shows the next entry on the following cycle.
- REQ-024: data_o is registered FIFO-head data. It is don't-care while valid_o is low, and ready_i has no effect when the FIFO is empty.
- REQ-025: If a push and a pop happen in the same cycle, both are accepted and count_o does not change. This also applies when the FIFO is full.
- REQ-026: A push into a full FIFO with no pop that cycle is dropped. overrun_o pulses and the FIFO contents are unchanged.
- REQ-027: Read and write pointers wrap modulo FIFO_DEPTH. count_o ranges 0..FIFO_DEPTH.
- REQ-028: The receiver never stalls on FIFO state. Reception continues during overrun.

Reset
- REQ-029: When reset_i is asserted, these values apply immediately and asynchronously:
  - State = IDLE.
  - Synchronizer flops = 1.
  - All counters and pointers = 0.
  - valid_o = 0, count_o = 0, data_o = 0, frame_err_o = 0, overrun_o = 0.
- REQ-030: Reset in the middle of a frame discards the partial byte and empties the FIFO.
- REQ-031: After reset is released, the first falling edge seen is treated as a start bit.

Configuration
- REQ-032: Macro SSC_TX_CAPTURE_STATS_EN controls the error counters.
  - Defined: add outputs frame_err_cnt_o[7:0] and overrun_cnt_o[7:0]. Each increments on its pulse, saturates at 255, and resets to 0.
  - Undefined: these ports and counters do not exist, and all other behaviour is identical.

Verification
- REQ-033: Default parameters, ready_i = 1, send 0xA5 8N1 at 5632 clocks per bit.
  - Required: valid_o high for exactly 1 cycle, with data_o = 0xA5.
  - Required: no frame_err_o pulse.
- REQ-034: ready_i = 0, send 17 bytes 0x00..0x10.
  - Required: count_o = 16 and a single overrun_o pulse on byte 0x10.
  - Then drive ready_i = 1. Required: pops return 0x00..0x0F in order.
- REQ-035: Send 0x55 with the stop bit held low, then hold the line low for 3 bit times.
  - Required: one frame_err_o pulse, no push.
  - Then send 0x3C. Required: 0x3C is received correctly.
- REQ-036: Drive a 2000-clock low glitch on an idle line.
  - Required: no push and no frame_err_o; the block is back in IDLE.
- REQ-037: FIFO full with ready_i = 1, timed so a push lands in the same cycle as a pop.
  - Required: count_o stays 16, no overrun_o, and the new byte is last in order.
- REQ-038: Assert reset_i during bit 4 of a frame.
  - Required: outputs take their reset values immediately, and the next full frame 0x81 is received correctly.
